decode_stage: RTL and testbench

- Instruction decode pipeline stage. Sits between fetch and execute: it takes raw 32-bit RV32I words plus PC from fetch and produces registered instruction::t records (op, rd/rs1/rs2 addresses, csr, sign-extended immediate) for the execute stage.
- Provides a valid/ready handshake on both sides, a 2-entry skid buffer for full-throughput backpressure, flush-to-NOP on redirect, and illegal-instruction flagging.

---
 rtl/decode_stage.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage with a 2-entry skid buffer, flush-to-NOP and illegal flagging.
// Optional: define DECODE_RV32M_EN to decode the RV32M multiply/divide encodings.

package op;
    typedef enum logic [5:0] {
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        FENCE, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } t;
endpackage

package instruction;
    typedef struct packed {
        op::t        op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] csr;
        logic [31:0] imm;
    } t;

    localparam t NOP = '{op::ADDI, 5'd0, 5'd0, 5'd0, 12'd0, 32'd0};
endpackage

module decode_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [31:0]                        in_word,
    input  logic [XLEN-1:0]                    in_pc,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$bits(instruction::t)-1:0]   out_instr,
    output logic [XLEN-1:0]                    out_pc,
    output logic                               out_illegal
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
    op::t          dec_op;
    fmt_t          fmt;
    logic          legal;
    logic          is_csr;
    instruction::t dec_rec;
    logic          dec_ill;

    assign f3    = in_word[14:12];
    assign f7    = in_word[31:25];
    assign imm_i = {{20{in_word[31]}}, in_word[31:20]};
    assign imm_s = {{20{in_word[31]}}, in_word[31:25], in_word[11:7]};
    assign imm_b = {{19{in_word[31]}}, in_word[31], in_word[7], in_word[30:25], in_word[11:8], 1'b0};
    assign imm_u = {in_word[31:12], 12'b0};
    assign imm_j = {{11{in_word[31]}}, in_word[31], in_word[19:12], in_word[20], in_word[30:21], 1'b0};

    // Opcode/funct selection: picks the mnemonic and the field layout.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_op = op::ADDI;
        fmt    = FMT_I;
        legal  = 1'b1;
        is_csr = 1'b0;
        case (in_word[6:2])
            OPC_LUI:   begin dec_op = op::LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin dec_op = op::AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin dec_op = op::JAL;   fmt = FMT_J; end
            OPC_JALR:  begin dec_op = op::JALR;  legal = (f3 == 3'b000); end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'b000:  dec_op = op::BEQ;
                    3'b001:  dec_op = op::BNE;
                    3'b100:  dec_op = op::BLT;
                    3'b101:  dec_op = op::BGE;
                    3'b110:  dec_op = op::BLTU;
                    3'b111:  dec_op = op::BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  dec_op = op::LB;
                    3'b001:  dec_op = op::LH;
                    3'b010:  dec_op = op::LW;
                    3'b100:  dec_op = op::LBU;
                    3'b101:  dec_op = op::LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'b000:  dec_op = op::SB;
                    3'b001:  dec_op = op::SH;
                    3'b010:  dec_op = op::SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000: dec_op = op::ADDI;
                    3'b010: dec_op = op::SLTI;
                    3'b011: dec_op = op::SLTIU;
                    3'b100: dec_op = op::XORI;
                    3'b110: dec_op = op::ORI;
                    3'b111: dec_op = op::ANDI;
                    3'b001: begin dec_op = op::SLLI; legal = (f7 == 7'b0000000); end
                    default: begin
                        if (f7 == 7'b0000000)      dec_op = op::SRLI;
                        else if (f7 == 7'b0100000) dec_op = op::SRAI;
                        else                       legal  = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec_op = op::ADD;
                            3'b001:  dec_op = op::SLL;
                            3'b010:  dec_op = op::SLT;
                            3'b011:  dec_op = op::SLTU;
                            3'b100:  dec_op = op::XOR;
                            3'b101:  dec_op = op::SRL;
                            3'b110:  dec_op = op::OR;
                            default: dec_op = op::AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  dec_op = op::SUB;
                            3'b101:  dec_op = op::SRA;
                            default: legal = 1'b0;
                        endcase
                    end
                    7'b0000001: begin
`ifdef DECODE_RV32M_EN
                        case (f3)
                            3'b000:  dec_op = op::MUL;
                            3'b001:  dec_op = op::MULH;
                            3'b010:  dec_op = op::MULHSU;
                            3'b011:  dec_op = op::MULHU;
                            3'b100:  dec_op = op::DIV;
                            3'b101:  dec_op = op::DIVU;
                            3'b110:  dec_op = op::REM;
                            default: dec_op = op::REMU;
                        endcase
`else
                        legal = 1'b0;
`endif
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_MISC_MEM: begin dec_op = op::FENCE; legal = (f3 == 3'b000); end
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (in_word[19:7] != 13'd0)          legal  = 1'b0;
                    else if (in_word[31:20] == 12'h000)  dec_op = op::ECALL;
                    else if (in_word[31:20] == 12'h001)  dec_op = op::EBREAK;
                    else                                 legal  = 1'b0;
                end else begin
                    is_csr = 1'b1;
                    case (f3)
                        3'b001:  dec_op = op::CSRRW;
                        3'b010:  dec_op = op::CSRRS;
                        3'b011:  dec_op = op::CSRRC;
                        3'b101:  dec_op = op::CSRRWI;
                        3'b110:  dec_op = op::CSRRSI;
                        3'b111:  dec_op = op::CSRRCI;
                        default: legal = 1'b0;
                    endcase
                end
            end
            default: legal = 1'b0;
        endcase
        if (in_word[1:0] != 2'b11) legal = 1'b0;
    end

    // Field assembly: unused fields of each format are forced to zero.
    always_comb begin
        dec_rec     = instruction::NOP;
        dec_ill     = 1'b0;
        dec_rec.op  = dec_op;
        dec_rec.rd  = in_word[11:7];
        dec_rec.rs1 = in_word[19:15];
        dec_rec.rs2 = in_word[24:20];
        dec_rec.csr = is_csr ? in_word[31:20] : 12'd0;
        case (fmt)
            FMT_R: dec_rec.imm = 32'd0;
            FMT_I: begin dec_rec.imm = imm_i; dec_rec.rs2 = 5'd0; end
            FMT_S: begin dec_rec.imm = imm_s; dec_rec.rd  = 5'd0; end
            FMT_B: begin dec_rec.imm = imm_b; dec_rec.rd  = 5'd0; end
            FMT_U: begin dec_rec.imm = imm_u; dec_rec.rs1 = 5'd0; dec_rec.rs2 = 5'd0; end
            default: begin dec_rec.imm = imm_j; dec_rec.rs1 = 5'd0; dec_rec.rs2 = 5'd0; end
        endcase
        if (!legal) begin
            dec_rec = instruction::NOP;
            dec_ill = 1'b1;
        end
    end

    state_t          state, state_nxt;
    instruction::t   or_rec, or_rec_nxt, sk_rec, sk_rec_nxt;
    logic [XLEN-1:0] or_pc, or_pc_nxt, sk_pc, sk_pc_nxt;
    logic            or_ill, or_ill_nxt, sk_ill, sk_ill_nxt;
    logic            accept, consume;

    assign out_valid   = (state != EMPTY);
    assign accept      = in_valid & in_ready;
    assign consume     = out_valid & out_ready;
    assign out_instr   = or_rec;
    assign out_pc      = or_pc;
    assign out_illegal = or_ill;

    always_comb begin
        state_nxt  = state;
        or_rec_nxt = or_rec;
        or_pc_nxt  = or_pc;
        or_ill_nxt = or_ill;
        sk_rec_nxt = sk_rec;
        sk_pc_nxt  = sk_pc;
        sk_ill_nxt = sk_ill;
        if (flush) begin
            state_nxt  = EMPTY;
            or_rec_nxt = instruction::NOP;
            or_pc_nxt  = RESET_PC_TAG;
            or_ill_nxt = 1'b0;
            sk_rec_nxt = instruction::NOP;
            sk_pc_nxt  = RESET_PC_TAG;
            sk_ill_nxt = 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt  = ONE;
                        or_rec_nxt = dec_rec;
                        or_pc_nxt  = in_pc;
                        or_ill_nxt = dec_ill;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        or_rec_nxt = dec_rec;
                        or_pc_nxt  = in_pc;
                        or_ill_nxt = dec_ill;
                    end else if (accept) begin
                        state_nxt  = FULL;
                        sk_rec_nxt = dec_rec;
                        sk_pc_nxt  = in_pc;
                        sk_ill_nxt = dec_ill;
                    end else if (consume) begin
                        // The output register reads as NOP/tag whenever nothing is valid.
                        state_nxt  = EMPTY;
                        or_rec_nxt = instruction::NOP;
                        or_pc_nxt  = RESET_PC_TAG;
                        or_ill_nxt = 1'b0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_nxt  = ONE;
                        or_rec_nxt = sk_rec;
                        or_pc_nxt  = sk_pc;
                        or_ill_nxt = sk_ill;
                        sk_rec_nxt = instruction::NOP;
                        sk_pc_nxt  = RESET_PC_TAG;
                        sk_ill_nxt = 1'b0;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            or_rec   <= instruction::NOP;
            or_pc    <= RESET_PC_TAG;
            or_ill   <= 1'b0;
            sk_rec   <= instruction::NOP;
            sk_pc    <= RESET_PC_TAG;
            sk_ill   <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
            or_rec   <= or_rec_nxt;
            or_pc    <= or_pc_nxt;
            or_ill   <= or_ill_nxt;
            sk_rec   <= sk_rec_nxt;
            sk_pc    <= sk_pc_nxt;
            sk_ill   <= sk_ill_nxt;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus for decode_stage, checked every cycle against a mask/match
// decode table and a queue model of the two-entry buffer, plus hand-computed literal expectations.
module tb_decode_stage;

    localparam logic [31:0] TAG = 32'h0000_0000;
    localparam int          RW  = $bits(instruction::t);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_word = 32'd0;
    logic [31:0]   in_pc = 32'd0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] out_instr;
    logic [31:0]   out_pc;
    logic          out_illegal;

    int n_checks = 0;
    int n_pass   = 0;
    bit live     = 1'b0;

    decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    instruction::t r;
    assign r = instruction::t'(out_instr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference decoder: RISC-V mask/match table plus per-format field rules.
    typedef enum {F_R, F_I, F_S, F_B, F_U, F_J} fmt_e;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        op::t        opc;
        fmt_e        fmt;
        bit          csr;
    } pat_t;
    typedef struct {
        instruction::t rec;
        logic [31:0]   pc;
        logic          ill;
    } item_t;

    pat_t        pats[$];
    item_t       model_q[$];
    logic [31:0] dut_log[$];

    function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                                input op::t o, input fmt_e f, input bit c);
        pat_t p;
        p.mask = mask; p.match = match; p.opc = o; p.fmt = f; p.csr = c;
        pats.push_back(p);
    endfunction

    function automatic void load_table();
        add(32'h7F, 32'h37, op::LUI, F_U, 0);
        add(32'h7F, 32'h17, op::AUIPC, F_U, 0);
        add(32'h7F, 32'h6F, op::JAL, F_J, 0);
        add(32'h707F, 32'h67, op::JALR, F_I, 0);
        add(32'h707F, 32'h63, op::BEQ, F_B, 0);
        add(32'h707F, 32'h1063, op::BNE, F_B, 0);
        add(32'h707F, 32'h4063, op::BLT, F_B, 0);
        add(32'h707F, 32'h5063, op::BGE, F_B, 0);
        add(32'h707F, 32'h6063, op::BLTU, F_B, 0);
        add(32'h707F, 32'h7063, op::BGEU, F_B, 0);
        add(32'h707F, 32'h03, op::LB, F_I, 0);
        add(32'h707F, 32'h1003, op::LH, F_I, 0);
        add(32'h707F, 32'h2003, op::LW, F_I, 0);
        add(32'h707F, 32'h4003, op::LBU, F_I, 0);
        add(32'h707F, 32'h5003, op::LHU, F_I, 0);
        add(32'h707F, 32'h23, op::SB, F_S, 0);
        add(32'h707F, 32'h1023, op::SH, F_S, 0);
        add(32'h707F, 32'h2023, op::SW, F_S, 0);
        add(32'h707F, 32'h13, op::ADDI, F_I, 0);
        add(32'h707F, 32'h2013, op::SLTI, F_I, 0);
        add(32'h707F, 32'h3013, op::SLTIU, F_I, 0);
        add(32'h707F, 32'h4013, op::XORI, F_I, 0);
        add(32'h707F, 32'h6013, op::ORI, F_I, 0);
        add(32'h707F, 32'h7013, op::ANDI, F_I, 0);
        add(32'hFE00707F, 32'h1013, op::SLLI, F_I, 0);
        add(32'hFE00707F, 32'h5013, op::SRLI, F_I, 0);
        add(32'hFE00707F, 32'h40005013, op::SRAI, F_I, 0);
        add(32'hFE00707F, 32'h33, op::ADD, F_R, 0);
        add(32'hFE00707F, 32'h40000033, op::SUB, F_R, 0);
        add(32'hFE00707F, 32'h1033, op::SLL, F_R, 0);
        add(32'hFE00707F, 32'h2033, op::SLT, F_R, 0);
        add(32'hFE00707F, 32'h3033, op::SLTU, F_R, 0);
        add(32'hFE00707F, 32'h4033, op::XOR, F_R, 0);
        add(32'hFE00707F, 32'h5033, op::SRL, F_R, 0);
        add(32'hFE00707F, 32'h40005033, op::SRA, F_R, 0);
        add(32'hFE00707F, 32'h6033, op::OR, F_R, 0);
        add(32'hFE00707F, 32'h7033, op::AND, F_R, 0);
`ifdef DECODE_RV32M_EN
        add(32'hFE00707F, 32'h02000033, op::MUL, F_R, 0);
        add(32'hFE00707F, 32'h02001033, op::MULH, F_R, 0);
        add(32'hFE00707F, 32'h02002033, op::MULHSU, F_R, 0);
        add(32'hFE00707F, 32'h02003033, op::MULHU, F_R, 0);
        add(32'hFE00707F, 32'h02004033, op::DIV, F_R, 0);
        add(32'hFE00707F, 32'h02005033, op::DIVU, F_R, 0);
        add(32'hFE00707F, 32'h02006033, op::REM, F_R, 0);
        add(32'hFE00707F, 32'h02007033, op::REMU, F_R, 0);
`endif
        add(32'h707F, 32'h0F, op::FENCE, F_I, 0);
        add(32'hFFFFFFFF, 32'h73, op::ECALL, F_I, 0);
        add(32'hFFFFFFFF, 32'h00100073, op::EBREAK, F_I, 0);
        add(32'h707F, 32'h1073, op::CSRRW, F_I, 1);
        add(32'h707F, 32'h2073, op::CSRRS, F_I, 1);
        add(32'h707F, 32'h3073, op::CSRRC, F_I, 1);
        add(32'h707F, 32'h5073, op::CSRRWI, F_I, 1);
        add(32'h707F, 32'h6073, op::CSRRSI, F_I, 1);
        add(32'h707F, 32'h7073, op::CSRRCI, F_I, 1);
    endfunction

    function automatic item_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        item_t              it;
        logic signed [31:0] sw;
        logic [31:0]        s20, s25, s31;
        sw  = $signed(w);
        s20 = sw >>> 20;
        s25 = sw >>> 25;
        s31 = sw >>> 31;
        it.pc  = pc;
        it.rec = instruction::NOP;
        it.ill = 1'b1;
        foreach (pats[i]) begin
            if ((w & pats[i].mask) == pats[i].match) begin
                it.ill      = 1'b0;
                it.rec.op   = pats[i].opc;
                it.rec.rd   = (pats[i].fmt == F_S || pats[i].fmt == F_B) ? 5'd0 : w[11:7];
                it.rec.rs1  = (pats[i].fmt == F_U || pats[i].fmt == F_J) ? 5'd0 : w[19:15];
                it.rec.rs2  = (pats[i].fmt == F_I || pats[i].fmt == F_U || pats[i].fmt == F_J) ? 5'd0 : w[24:20];
                it.rec.csr  = pats[i].csr ? w[31:20] : 12'd0;
                case (pats[i].fmt)
                    F_I:     it.rec.imm = s20;
                    F_S:     it.rec.imm = {s25[26:0], w[11:7]};
                    F_B:     it.rec.imm = {s31[19:0], w[7], w[30:25], w[11:8], 1'b0};
                    F_U:     it.rec.imm = {w[31:12], 12'd0};
                    F_J:     it.rec.imm = {s31[11:0], w[19:12], w[20], w[30:21], 1'b0};
                    default: it.rec.imm = 32'd0;
                endcase
            end
        end
        return it;
    endfunction

    // Buffer model: a queue of at most two accepted records, in accept order.
    always @(posedge clk) begin : model_update
        bit    acc, con;
        item_t nw;
        if (rst_n && !flush && out_valid === 1'b1 && out_ready) dut_log.push_back(out_pc);
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            acc = in_valid && (model_q.size() < 2);
            con = (model_q.size() > 0) && out_ready;
            nw  = ref_decode(in_word, in_pc);
            if (con) void'(model_q.pop_front());
            if (acc) model_q.push_back(nw);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("in_ready", in_ready, model_q.size() < 2);
            check("out_valid", out_valid, model_q.size() > 0);
            if (model_q.size() > 0) begin
                check("out_instr", out_instr, model_q[0].rec);
                check("out_pc", out_pc, model_q[0].pc);
                check("out_illegal", out_illegal, model_q[0].ill);
            end else begin
                check("idle_instr", out_instr, instruction::NOP);
                check("idle_pc", out_pc, TAG);
                check("idle_illegal", out_illegal, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input string nm, input op::t o, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] csr,
                              input logic [31:0] imm, input logic [31:0] pc, input logic ill);
        check({nm, ".valid"}, out_valid, 1'b1);
        check({nm, ".op"}, r.op, o);
        check({nm, ".rd"}, r.rd, rd);
        check({nm, ".rs1"}, r.rs1, rs1);
        check({nm, ".rs2"}, r.rs2, rs2);
        check({nm, ".csr"}, r.csr, csr);
        check({nm, ".imm"}, r.imm, imm);
        check({nm, ".pc"}, out_pc, pc);
        check({nm, ".illegal"}, out_illegal, ill);
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_word  = w;
        in_pc    = pc;
    endtask

    logic [31:0] words [6] = '{32'h002081B3, 32'h40418233, 32'h123452B7,
                               32'h0080036F, 32'h00F47393, 32'h0014D413};

    initial begin : main
        item_t pin;
        int    k, c, stalls;
        bit    rdy;

        load_table();
        pin = ref_decode(32'hFFF10093, 32'd0);
        check("model_addi_imm", pin.rec.imm, 32'hFFFF_FFFF);
        pin = ref_decode(32'hFE000EE3, 32'd0);
        check("model_beq_imm", pin.rec.imm, 32'hFFFF_FFFC);

        @(posedge clk);
        live = 1'b1;
        step();
        check("reset_valid", out_valid, 1'b0);
        check("reset_instr", out_instr, instruction::NOP);
        check("reset_pc", out_pc, TAG);
        check("reset_illegal", out_illegal, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        step();

        send(32'hFFF10093, 32'h100);
        step();
        in_valid = 1'b0;
        expect_rec("addi", op::ADDI, 5'd1, 5'd2, 5'd0, 12'h0, 32'hFFFF_FFFF, 32'h100, 1'b0);
        step();

        send(32'h00532423, 32'h104);
        step();
        expect_rec("sw", op::SW, 5'd0, 5'd6, 5'd5, 12'h0, 32'd8, 32'h104, 1'b0);
        send(32'hFE000EE3, 32'h108);
        step();
        in_valid = 1'b0;
        expect_rec("beq", op::BEQ, 5'd0, 5'd0, 5'd0, 12'h0, 32'hFFFF_FFFC, 32'h108, 1'b0);
        step();

        send(32'h300110F3, 32'h10C);
        step();
        in_valid = 1'b0;
        expect_rec("csrrw", op::CSRRW, 5'd1, 5'd2, 5'd0, 12'h300, 32'h300, 32'h10C, 1'b0);
        step();

        // Six-word stream with the consumer stalled in cycles 2..4.
        dut_log.delete();
        k = 0; c = 0; stalls = 0;
        while (k < 6 && c < 40) begin
            out_ready = !(c >= 2 && c <= 4);
            send(words[k], 32'h200 + 32'(4 * k));
            rdy = in_ready;
            if (!rdy) stalls++;
            step();
            if (rdy) k++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("stream_accepted", k, 6);
        check("stream_full_cycles", stalls, 3);
        check("stream_count", dut_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("stream_order%0d", i), (i < dut_log.size()) ? dut_log[i] : 32'hDEAD_BEEF,
                  32'h200 + 32'(4 * i));

        // Flush while FULL with a word offered.
        out_ready = 1'b0;
        send(words[0], 32'h300);
        step();
        send(words[1], 32'h304);
        step();
        check("full_in_ready", in_ready, 1'b0);
        send(words[2], 32'h308);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_instr", out_instr, instruction::NOP);
        check("flush_pc", out_pc, TAG);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        dut_log.delete();
        send(words[3], 32'h30C);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();
        check("flush_nothing_leaks", dut_log.size(), 0);

        // Reset while FULL drops both held words.
        out_ready = 1'b0;
        send(words[4], 32'h310);
        step();
        send(words[5], 32'h314);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();

        // Illegal word, then an M-extension word.
        send(32'h0000_0000, 32'h400);
        step();
        expect_rec("zero_word", op::ADDI, 5'd0, 5'd0, 5'd0, 12'h0, 32'd0, 32'h400, 1'b1);
        send(32'h02208033, 32'h404);
        step();
        in_valid = 1'b0;
`ifdef DECODE_RV32M_EN
        expect_rec("mul", op::MUL, 5'd0, 5'd1, 5'd2, 12'h0, 32'd0, 32'h404, 1'b0);
`else
        expect_rec("mul", op::ADDI, 5'd0, 5'd0, 5'd0, 12'h0, 32'd0, 32'h404, 1'b1);
`endif
        repeat (3) step();

        live = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
